// File: rtl/trigger_capture_buffer.sv
// Dual-bank triggered capture: samples stream into a circular write bank around a trigger,
// and on lock the banks swap so the finished frame is readable at offsets from the trigger.
module trigger_capture_buffer #(
    parameter int unsigned LOG_SAMPLES = 10,
    parameter int unsigned SAMPLE_SIZE = 12,
    parameter int unsigned CHANNELS    = 2,
    localparam int unsigned CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            ready,
    input  logic [CHANNELS*SAMPLE_SIZE-1:0] data_in,
    input  logic                            is_trigger,
    input  logic                            arm,
    input  logic                            hold,
    input  logic [LOG_SAMPLES-1:0]          pre_trigger,
    input  logic [CH_BITS-1:0]              read_channel,
    input  logic [LOG_SAMPLES-1:0]          read_address,
    output logic [SAMPLE_SIZE-1:0]          read_data,
    output logic                            frame_valid,
    output logic                            capture_done,
    output logic [1:0]                      state
);
    localparam int unsigned DEPTH = 1 << LOG_SAMPLES;
    localparam logic [LOG_SAMPLES-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WAIT = 2'd2,
        S_POST = 2'd3
    } state_t;

    state_t                 r_state;
    logic [LOG_SAMPLES-1:0] r_wr_ptr;
    logic [LOG_SAMPLES-1:0] r_trig_ptr;
    logic [LOG_SAMPLES-1:0] r_disp_trig;
    logic [LOG_SAMPLES-1:0] r_pre_lat;
    logic [LOG_SAMPLES-1:0] r_fill_cnt;
    logic [LOG_SAMPLES-1:0] r_post_cnt;
    logic                   r_wr_bank;
    logic                   r_frame_valid;
    logic                   r_capture_done;

    logic [SAMPLE_SIZE-1:0] r_mem [2][CHANNELS][DEPTH];

    logic                   r_rd_bank;
    logic [CH_BITS-1:0]     r_rd_ch;
    logic [LOG_SAMPLES-1:0] r_rd_addr;
    logic [SAMPLE_SIZE-1:0] r_read_data;

    logic                   w_accept;
    logic [LOG_SAMPLES-1:0] w_post_target;
    logic [LOG_SAMPLES-1:0] w_fill_next;
    logic [LOG_SAMPLES-1:0] w_post_next;
    logic                   w_rd_ch_ok;

    assign w_accept      = ready && !hold && (r_state != S_IDLE);
    assign w_post_target = LAST_IDX - r_pre_lat;
    assign w_fill_next   = r_fill_cnt + 1'b1;
    assign w_post_next   = r_post_cnt + 1'b1;
    assign w_rd_ch_ok    = {1'b0, r_rd_ch} < (CH_BITS + 1)'(CHANNELS);

    assign state         = r_state;
    assign frame_valid   = r_frame_valid;
    assign capture_done  = r_capture_done;
    assign read_data     = r_read_data;

    // Capture sequencing; hold freezes everything except the done pulse clearing.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_trig_ptr     <= '0;
            r_disp_trig    <= '0;
            r_pre_lat      <= '0;
            r_fill_cnt     <= '0;
            r_post_cnt     <= '0;
            r_wr_bank      <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_capture_done <= 1'b0;
        end else begin
            r_capture_done <= 1'b0;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (!hold) begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            r_pre_lat  <= pre_trigger;
                            r_fill_cnt <= '0;
                            r_post_cnt <= '0;
                            r_state    <= (pre_trigger == '0) ? S_WAIT : S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (ready) begin
                            r_fill_cnt <= w_fill_next;
                            if (w_fill_next == r_pre_lat) begin
                                r_state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (ready && is_trigger) begin
                            r_trig_ptr <= r_wr_ptr;
                            if (w_post_target == '0) begin
                                r_wr_bank      <= ~r_wr_bank;
                                r_disp_trig    <= r_wr_ptr;
                                r_frame_valid  <= 1'b1;
                                r_capture_done <= 1'b1;
                                r_state        <= S_IDLE;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (ready) begin
                            r_post_cnt <= w_post_next;
                            if (w_post_next == w_post_target) begin
                                r_wr_bank      <= ~r_wr_bank;
                                r_disp_trig    <= r_trig_ptr;
                                r_frame_valid  <= 1'b1;
                                r_capture_done <= 1'b1;
                                r_state        <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Sample storage is not cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_mem[r_wr_bank][CH_BITS'(k)][r_wr_ptr] <= data_in[k*SAMPLE_SIZE +: SAMPLE_SIZE];
            end
        end
    end

    // Bank is captured with the address so a swap mid-read stays on one bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_bank   <= 1'b1;
            r_rd_ch     <= '0;
            r_rd_addr   <= '0;
            r_read_data <= '0;
        end else begin
            r_rd_bank   <= ~r_wr_bank;
            r_rd_ch     <= read_channel;
            r_rd_addr   <= r_disp_trig + read_address;
            r_read_data <= w_rd_ch_ok ? r_mem[r_rd_bank][r_rd_ch][r_rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Randomized and directed checks of trigger_capture_buffer against a sample-history model.
module tb_trigger_capture_buffer;
    localparam int unsigned LS = 4;
    localparam int unsigned SS = 12;
    localparam int unsigned CH = 2;
    localparam int N = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              ready;
    logic [CH*SS-1:0]  data_in;
    logic              is_trigger;
    logic              arm;
    logic              hold;
    logic [LS-1:0]     pre_trigger;
    logic [0:0]        read_channel;
    logic [LS-1:0]     read_address;
    logic [SS-1:0]     read_data;
    logic              frame_valid;
    logic              capture_done;
    logic [1:0]        state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    trigger_capture_buffer #(
        .LOG_SAMPLES (LS),
        .SAMPLE_SIZE (SS),
        .CHANNELS    (CH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .data_in      (data_in),
        .is_trigger   (is_trigger),
        .arm          (arm),
        .hold         (hold),
        .pre_trigger  (pre_trigger),
        .read_channel (read_channel),
        .read_address (read_address),
        .read_data    (read_data),
        .frame_valid  (frame_valid),
        .capture_done (capture_done),
        .state        (state)
    );

    // Model: capture progress is described by samples taken since arm and where the trigger fell.
    bit          m_live = 0;
    bit          m_armed, m_trig_seen, m_wbank, m_fv, m_done;
    int          m_pre, m_n, m_trig_idx;
    logic [3:0]  m_trig_addr, m_wptr, m_disp_trig;
    logic [SS-1:0] m_mem [2][CH][N];
    bit          m_known [2][CH][N];
    bit          s1_bank;
    int          s1_ch;
    logic [3:0]  s1_addr;
    logic [SS-1:0] exp_rd;
    bit          exp_rd_known;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_armed)          return 2'd0;
        if (m_n < m_pre)       return 2'd1;
        if (!m_trig_seen)      return 2'd2;
        return 2'd3;
    endfunction

    task automatic model_step();
        int idx;
        if (s1_ch < int'(CH)) begin
            exp_rd       = m_mem[s1_bank][s1_ch][s1_addr];
            exp_rd_known = m_known[s1_bank][s1_ch][s1_addr];
        end else begin
            exp_rd       = '0;
            exp_rd_known = 1;
        end
        s1_bank = ~m_wbank;
        s1_ch   = int'(read_channel);
        s1_addr = m_disp_trig + read_address;
        if (reset) begin
            exp_rd = '0; exp_rd_known = 1;
            s1_bank = 1; s1_ch = 0; s1_addr = '0;
            m_armed = 0; m_trig_seen = 0; m_n = 0; m_pre = 0; m_trig_idx = 0;
            m_wptr = '0; m_trig_addr = '0; m_disp_trig = '0;
            m_wbank = 0; m_fv = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (hold) return;
        if (!m_armed) begin
            if (arm) begin
                m_armed = 1; m_pre = int'(pre_trigger); m_n = 0; m_trig_seen = 0;
            end
            return;
        end
        if (!ready) return;
        for (int c = 0; c < int'(CH); c++) begin
            m_mem[m_wbank][c][m_wptr]   = data_in[c*SS +: SS];
            m_known[m_wbank][c][m_wptr] = 1;
        end
        idx = m_n;
        m_n++;
        if (!m_trig_seen && idx >= m_pre && is_trigger) begin
            m_trig_seen = 1; m_trig_idx = idx; m_trig_addr = m_wptr;
        end
        m_wptr = m_wptr + 4'd1;
        if (m_trig_seen && m_n == m_trig_idx + 1 + (N - 1 - m_pre)) begin
            m_wbank = ~m_wbank; m_disp_trig = m_trig_addr;
            m_fv = 1; m_done = 1; m_armed = 0;
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (m_live) begin
            check("state", 32'(state), 32'(exp_state()));
            check("frame_valid", 32'(frame_valid), 32'(m_fv));
            check("capture_done", 32'(capture_done), 32'(m_done));
            if (exp_rd_known) check("read_data", 32'(read_data), 32'(exp_rd));
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        m_live = 1;
        @(negedge clock);
    endtask

    task automatic do_arm(input int p);
        arm = 1; pre_trigger = LS'(p); ready = 0; is_trigger = 0;
        tick();
        arm = 0;
    endtask

    task automatic samp(input int v, input bit trig);
        ready = 1; is_trigger = trig;
        data_in = {SS'(v + 100), SS'(v)};
        tick();
        ready = 0; is_trigger = 0;
    endtask

    task automatic read_lit(input string name, input int ch, input int off, input int exp);
        read_channel = 1'(ch); read_address = LS'(off); ready = 0;
        tick();
        tick();
        check(name, 32'(read_data), 32'(exp));
    endtask

    initial begin
        reset = 1; ready = 0; data_in = '0; is_trigger = 0; arm = 0; hold = 0;
        pre_trigger = '0; read_channel = '0; read_address = '0;
        repeat (3) tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_read_data", 32'(read_data), 32'd0);
        reset = 0;

        // Ramp with pre-trigger 4, trigger on value 20.
        do_arm(4);
        for (int v = 0; v < 32; v++) samp(v, v == 20);
        check("ramp_done", 32'(capture_done), 32'd1);
        read_lit("ramp_off0", 0, 0, 20);
        read_lit("ramp_offm4", 0, -4, 16);
        read_lit("ramp_off11", 0, 11, 31);

        // Trigger during fill ignored; read ch1 across the swap cycle.
        do_arm(4);
        for (int i = 0; i < 18; i++) begin
            if (i == 17) begin read_channel = 1'b1; read_address = '0; end
            samp(100 + i, i == 2 || i == 6);
            if (i == 3) check("fill_ignores_trig", 32'(state), 32'd2);
        end
        check("fill_case_done", 32'(capture_done), 32'd1);
        read_address = 4'd5; read_channel = 1'b0;
        tick();
        check("swap_read_ch1", 32'(read_data), 32'd120);
        read_lit("fill_case_off0", 0, 0, 106);

        // pre_trigger = 0 and 15.
        do_arm(0);
        samp(200, 1);
        for (int i = 1; i < 16; i++) samp(200 + i, 0);
        check("pre0_done", 32'(capture_done), 32'd1);
        read_lit("pre0_off0", 0, 0, 200);
        do_arm(15);
        for (int i = 0; i < 15; i++) samp(300 + i, i == 5);
        samp(315, 1);
        check("pre15_done", 32'(capture_done), 32'd1);
        read_lit("pre15_offp1", 0, 1, 300);

        // Hold in POST freezes progress and drops samples.
        do_arm(2);
        samp(400, 0); samp(401, 0); samp(402, 1);
        for (int i = 403; i < 408; i++) samp(i, 0);
        hold = 1;
        for (int i = 0; i < 5; i++) samp(999, 1);
        check("hold_state", 32'(state), 32'd3);
        hold = 0;
        for (int i = 408; i < 416; i++) samp(i, 0);
        check("hold_done", 32'(capture_done), 32'd1);
        read_lit("hold_offp6", 0, 6, 408);
        read_lit("hold_offm2", 0, -2, 400);
        read_lit("hold_offp13", 1, 13, 515);

        // Reset mid-POST aborts without swap.
        do_arm(3);
        for (int i = 0; i < 10; i++) samp(500 + i, i == 5);
        reset = 1;
        tick();
        reset = 0;
        tick();
        check("abort_state", 32'(state), 32'd0);
        check("abort_frame_valid", 32'(frame_valid), 32'd0);
        do_arm(3);
        for (int i = 0; i < 6; i++) samp(600 + i, 0);
        for (int off = 0; off < N; off += 3) begin
            read_channel = 1'(off & 1); read_address = LS'(off);
            tick();
        end
        tick();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            arm          = ($urandom_range(0, 7) == 0);
            pre_trigger  = LS'($urandom_range(0, N - 1));
            ready        = ($urandom_range(0, 3) != 0);
            hold         = ($urandom_range(0, 9) == 0);
            is_trigger   = ($urandom_range(0, 5) == 0);
            data_in      = CH*SS'($urandom);
            read_channel = 1'($urandom_range(0, 1));
            read_address = LS'($urandom_range(0, N - 1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
